// File: rtl/cam_drain.sv
// Drains a pending CAM/writeback queue one entry at a time onto a request/response bus,
// retrying NACKed requests after a fixed backoff and dropping entries once retries run out.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no entry in flight; start the queue head when allowed
// REQ     | bus_req held with the latched entry until the bus grants it
// WAIT    | request accepted, waiting for the response strobe
// BACKOFF | NACK received, counting down before reissuing the same entry
// POP     | one-cycle fifo_pop to retire the head entry
module cam_drain #(
    parameter int WIDTH     = 59,
    parameter int CAM_WIDTH = 58,
    parameter int BACKOFF   = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop,
    output logic             bus_req,
    output logic             bus_reqcmd,
    output logic [63:0]      bus_reqaddr,
    input  logic             bus_reqack,
    input  logic             bus_resp,
    input  logic             bus_resp_ok,
    output logic             busy,
    output logic             err,
    output logic [15:0]      done_count
);

    localparam int RETRY_BITS = $clog2(MAX_RETRY + 1);
    localparam int RETRY_W    = (RETRY_BITS > 2) ? RETRY_BITS : 2;
    localparam int BO_W       = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [BO_W-1:0]    BO_LOAD   = BO_W'(BACKOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_BACKOFF,
        S_POP
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     entry_q;
    logic [RETRY_W-1:0]   retry_q;
    logic [BO_W-1:0]      bo_cnt;
    logic                 ready_q;

    assign bus_reqcmd  = entry_q[WIDTH-1];
    assign bus_reqaddr = 64'(entry_q[CAM_WIDTH-1:0]) << 6;

    // ready_q keeps the first edge after reset release from starting an entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            entry_q    <= '0;
            retry_q    <= '0;
            bo_cnt     <= '0;
            ready_q    <= 1'b0;
            bus_req    <= 1'b0;
            fifo_pop   <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            done_count <= '0;
        end else begin
            ready_q  <= 1'b1;
            fifo_pop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ready_q && !fifo_empty && !hold) begin
                        entry_q <= fifo_data;
                        retry_q <= '0;
                        state   <= S_REQ;
                        bus_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus_reqack) begin
                        state   <= S_WAIT;
                        bus_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus_resp) begin
                        if (bus_resp_ok) begin
                            state    <= S_POP;
                            fifo_pop <= 1'b1;
                        end else if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + RETRY_W'(1);
                            bo_cnt  <= BO_LOAD;
                            state   <= S_BACKOFF;
                        end else begin
                            err      <= 1'b1;
                            state    <= S_POP;
                            fifo_pop <= 1'b1;
                        end
                    end
                end
                S_BACKOFF: begin
                    if (bo_cnt == '0) begin
                        state   <= S_REQ;
                        bus_req <= 1'b1;
                    end else begin
                        bo_cnt <= bo_cnt - BO_W'(1);
                    end
                end
                S_POP: begin
                    done_count <= done_count + 16'd1;
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_drain.sv
// Directed bench for cam_drain: a vector table of single-entry transactions plus
// hand-written sequences for hold/back-to-back, start-after-reset and async reset.
module tb_cam_drain;

    localparam int BACKOFF   = 4;
    localparam int MAX_RETRY = 3;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        fifo_empty;
    logic [58:0] fifo_data;
    logic        fifo_pop;
    logic        bus_req;
    logic        bus_reqcmd;
    logic [63:0] bus_reqaddr;
    logic        bus_reqack;
    logic        bus_resp;
    logic        bus_resp_ok;
    logic        busy;
    logic        err;
    logic [15:0] done_count;

    int checks = 0;
    int errors = 0;

    logic [58:0] q[$];
    logic [58:0] popped[$];

    cam_drain #(
        .WIDTH(59), .CAM_WIDTH(58), .BACKOFF(BACKOFF), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .bus_req(bus_req), .bus_reqcmd(bus_reqcmd), .bus_reqaddr(bus_reqaddr),
        .bus_reqack(bus_reqack), .bus_resp(bus_resp), .bus_resp_ok(bus_resp_ok),
        .busy(busy), .err(err), .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [58:0] entry;
        int          grant_wait;
        int          nacks;
        logic [63:0] exp_addr;
        logic        exp_cmd;
        int          exp_reqs;
        logic        exp_err;
        logic [15:0] exp_done;
        bit          rst_first;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : '0;
    endtask

    // Upstream queue model: the head retires on each fifo_pop pulse.
    always @(negedge clk) begin
        if (fifo_pop) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL pop_while_empty: got pop=1 expected no pop with empty queue");
            end else begin
                popped.push_back(q.pop_front());
            end
            refresh();
        end
    end

    task automatic do_reset();
        reset       = 1'b0;
        hold        = 1'b0;
        bus_reqack  = 1'b0;
        bus_resp    = 1'b0;
        bus_resp_ok = 1'b0;
        q.delete();
        popped.delete();
        refresh();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_txn(input vec_t v, input bit push);
        int          reqs;
        int          gap;
        bit          got;
        bit          ok_resp;
        logic [63:0] addr0;
        if (push) begin
            q.push_back(v.entry);
            refresh();
        end
        reqs = 0;
        forever begin
            gap = 0;
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                bus_resp    = 1'b0;
                bus_resp_ok = 1'b0;
                if (bus_req) begin
                    got = 1'b1;
                    break;
                end
                gap++;
            end
            if (!got) begin
                chk("req_timeout", 64'(got), 64'd1);
                return;
            end
            reqs++;
            if (reqs > 1) chk("backoff_gap", 64'(gap), 64'(BACKOFF));
            chk("req_addr", bus_reqaddr, v.exp_addr);
            chk("req_cmd", 64'(bus_reqcmd), 64'(v.exp_cmd));
            addr0 = bus_reqaddr;
            for (int s = 0; s < v.grant_wait; s++) begin
                bus_resp    = 1'b1;
                bus_resp_ok = 1'b1;
                @(negedge clk);
                chk("stall_req", 64'(bus_req), 64'd1);
                chk("stall_addr", bus_reqaddr, addr0);
                chk("stall_pop", 64'(fifo_pop), 64'd0);
            end
            bus_resp   = 1'b0;
            bus_reqack = 1'b1;
            @(negedge clk);
            bus_reqack = 1'b0;
            chk("wait_req_low", 64'(bus_req), 64'd0);
            ok_resp     = (reqs > v.nacks);
            bus_resp    = 1'b1;
            bus_resp_ok = ok_resp;
            if (ok_resp || reqs == MAX_RETRY + 1) break;
        end
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus_resp    = 1'b0;
            bus_resp_ok = 1'b0;
            if (fifo_pop) begin
                got = 1'b1;
                break;
            end
        end
        chk("pop_seen", 64'(got), 64'd1);
        @(negedge clk);
        chk("pop_one_cycle", 64'(fifo_pop), 64'd0);
        chk("done_count", 64'(done_count), 64'(v.exp_done));
        chk("err", 64'(err), 64'(v.exp_err));
        chk("req_count", 64'(reqs), 64'(v.exp_reqs));
        chk("popped_count", 64'(popped.size() > 0), 64'd1);
        if (popped.size() > 0) chk("popped_entry", 64'(popped[popped.size()-1]), 64'(v.entry));
    endtask

    initial begin
        int          pops;
        int          last;
        int          minsp;
        bit          resp_next;
        bit          got;
        int          seen;
        logic [58:0] e0;
        logic [58:0] e1;
        logic [58:0] e2;
        vec_t        vr;

        vecs[0] = '{{1'b1, 58'h3},              0,  0, 64'hC0,                1'b1, 1, 1'b0, 16'd1, 1'b1};
        vecs[1] = '{{1'b0, 58'h12345},          10, 0, 64'h48D140,            1'b0, 1, 1'b0, 16'd1, 1'b1};
        vecs[2] = '{{1'b1, 58'h1_0000_0001},    0,  1, 64'h40_0000_0040,      1'b1, 2, 1'b0, 16'd1, 1'b1};
        vecs[3] = '{{1'b0, 58'h3FF_FFFF_FFFF_FFFF}, 0, 4, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 4, 1'b1, 16'd1, 1'b1};
        vecs[4] = '{{1'b1, 58'h7},              0,  1, 64'h1C0,               1'b1, 2, 1'b1, 16'd2, 1'b0};

        reset       = 1'b0;
        hold        = 1'b0;
        bus_reqack  = 1'b0;
        bus_resp    = 1'b0;
        bus_resp_ok = 1'b0;
        refresh();
        #1;
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_fifo_pop", 64'(fifo_pop), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_done_count", 64'(done_count), 64'd0);

        // First start may not happen on the first edge after reset release.
        q.push_back({1'b1, 58'h5});
        refresh();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("no_start_first_edge", 64'(busy), 64'd0);
        @(negedge clk);
        chk("start_second_edge", 64'(bus_req), 64'd1);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].rst_first) do_reset();
            run_txn(vecs[i], 1'b1);
        end

        // Hold blocks starts; release drains three entries back to back.
        do_reset();
        e0 = {1'b1, 58'h11};
        e1 = {1'b0, 58'h22};
        e2 = {1'b1, 58'h33};
        hold = 1'b1;
        q.push_back(e0);
        q.push_back(e1);
        q.push_back(e2);
        refresh();
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus_req || busy) seen++;
        end
        chk("hold_no_req", 64'(seen), 64'd0);
        hold       = 1'b0;
        bus_reqack = 1'b1;
        pops       = 0;
        last       = 0;
        minsp      = 1000;
        resp_next  = 1'b0;
        for (int cyc = 0; cyc < 60 && pops < 3; cyc++) begin
            @(negedge clk);
            bus_resp    = resp_next;
            bus_resp_ok = 1'b1;
            resp_next   = bus_req;
            if (fifo_pop) begin
                if (pops > 0 && (cyc - last) < minsp) minsp = cyc - last;
                last = cyc;
                pops++;
            end
        end
        @(negedge clk);
        bus_reqack = 1'b0;
        bus_resp   = 1'b0;
        chk("b2b_pops", 64'(pops), 64'd3);
        chk("b2b_spacing_ge4", 64'(minsp >= 4), 64'd1);
        chk("b2b_done_count", 64'(done_count), 64'd3);
        chk("b2b_popped_n", 64'(popped.size()), 64'd3);
        if (popped.size() == 3) begin
            chk("b2b_order0", 64'(popped[0]), 64'(e0));
            chk("b2b_order1", 64'(popped[1]), 64'(e1));
            chk("b2b_order2", 64'(popped[2]), 64'(e2));
        end

        // Async reset while waiting for a response abandons the request.
        do_reset();
        vr = '{{1'b1, 58'hABC}, 0, 0, 64'h2AF00, 1'b1, 1, 1'b0, 16'd1, 1'b1};
        q.push_back(vr.entry);
        refresh();
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_req) begin
                got = 1'b1;
                break;
            end
        end
        chk("rw_req_seen", 64'(got), 64'd1);
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
        chk("rw_in_wait_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rw_async_bus_req", 64'(bus_req), 64'd0);
        chk("rw_async_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rw_done_zero", 64'(done_count), 64'd0);
        chk("rw_entry_kept", 64'(q.size()), 64'd1);
        run_txn(vr, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
